// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue for the back end.
// Allocates ROB tags, marks completion from add/mul broadcasts, retires in order.
module reorder_buffer #(
  parameter  int DEPTH = 16,
  parameter  int NAREG = 8,
  localparam int TW    = $clog2(DEPTH),
  localparam int RW    = $clog2(NAREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stop,
  input  logic          valid_issue_reg,
  input  logic [RW-1:0] Rw_reg,
  input  logic [TW-1:0] tag_PRF,
  input  logic [TW-1:0] tag_Rw_old,
  output logic [TW-1:0] tag_ROB,
  output logic          full_ROB,
  output logic          empty_ROB,
  input  logic          valid_Result_add,
  input  logic [TW-1:0] tag_ROB_add,
  input  logic          valid_Result_mul,
  input  logic [TW-1:0] tag_ROB_mul,
  output logic          commit_valid,
  output logic [RW-1:0] commit_Rw,
  output logic [TW-1:0] commit_tag_PRF,
  output logic          free_valid,
  output logic [TW-1:0] free_tag,
  output logic [TW-1:0] ARF_tag [0:NAREG-1]
);

  typedef struct packed {
    logic          valid;
    logic          done;
    logic [RW-1:0] rw;
    logic [TW-1:0] tag_p;
    logic [TW-1:0] tag_old;
  } rob_entry_t;

  rob_entry_t    rob_q [DEPTH];
  logic [TW-1:0] head_q;
  logic [TW-1:0] tail_q;
  logic [TW:0]   count_q;
  rob_entry_t    head_e;
  logic          alloc;
  logic          commit;

  assign full_ROB  = (count_q == (TW+1)'(DEPTH));
  assign empty_ROB = (count_q == '0);
  assign tag_ROB   = tail_q;

  // Flags come from registered count only, so a retiring
  // slot is never reused in the same cycle.
  assign alloc  = valid_issue_reg & ~full_ROB & ~stop;
  assign head_e = rob_q[head_q];
  assign commit = head_e.valid & head_e.done;

  assign commit_valid   = commit;
  assign free_valid     = commit;
  assign commit_Rw      = commit ? head_e.rw      : '0;
  assign commit_tag_PRF = commit ? head_e.tag_p   : '0;
  assign free_tag       = commit ? head_e.tag_old : '0;

  // Entry state, pointers, count and committed map.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      for (int i = 0; i < NAREG; i++) begin
        ARF_tag[i] <= TW'(i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rob_q[i].valid &&
            ((valid_Result_add && tag_ROB_add == TW'(i)) ||
             (valid_Result_mul && tag_ROB_mul == TW'(i)))) begin
          rob_q[i].done <= 1'b1;
        end
      end
      if (commit) begin
        rob_q[head_q].valid <= 1'b0;
        rob_q[head_q].done  <= 1'b0;
        head_q              <= head_q + TW'(1);
        ARF_tag[head_e.rw]  <= head_e.tag_p;
      end
      if (alloc) begin
        rob_q[tail_q] <= '{valid:   1'b1,
                           done:    1'b0,
                           rw:      Rw_reg,
                           tag_p:   tag_PRF,
                           tag_old: tag_Rw_old};
        tail_q <= tail_q + TW'(1);
      end
      count_q <= count_q + (TW+1)'(alloc) - (TW+1)'(commit);
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: table vectors plus commit scoreboard
// for the reorder_buffer retirement queue.
module tb_reorder_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stop = 1'b0;
  logic       valid_issue_reg = 1'b0;
  logic [2:0] Rw_reg = '0;
  logic [3:0] tag_PRF = '0;
  logic [3:0] tag_Rw_old = '0;
  logic [3:0] tag_ROB;
  logic       full_ROB;
  logic       empty_ROB;
  logic       valid_Result_add = 1'b0;
  logic [3:0] tag_ROB_add = '0;
  logic       valid_Result_mul = 1'b0;
  logic [3:0] tag_ROB_mul = '0;
  logic       commit_valid;
  logic [2:0] commit_Rw;
  logic [3:0] commit_tag_PRF;
  logic       free_valid;
  logic [3:0] free_tag;
  logic [3:0] arf [0:7];

  reorder_buffer dut (
    .clk(clk), .rst(rst), .stop(stop),
    .valid_issue_reg(valid_issue_reg),
    .Rw_reg(Rw_reg), .tag_PRF(tag_PRF),
    .tag_Rw_old(tag_Rw_old), .tag_ROB(tag_ROB),
    .full_ROB(full_ROB), .empty_ROB(empty_ROB),
    .valid_Result_add(valid_Result_add),
    .tag_ROB_add(tag_ROB_add),
    .valid_Result_mul(valid_Result_mul),
    .tag_ROB_mul(tag_ROB_mul),
    .commit_valid(commit_valid),
    .commit_Rw(commit_Rw),
    .commit_tag_PRF(commit_tag_PRF),
    .free_valid(free_valid), .free_tag(free_tag),
    .ARF_tag(arf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst_before;
    bit         disp;
    logic [2:0] rw;
    logic [3:0] tp;
    logic [3:0] to;
    bit         av;
    logic [3:0] at;
    bit         mv;
    logic [3:0] mt;
    bit         stp;
    bit         e_cv;
    logic [3:0] e_free;
    bit         e_empty;
    bit         e_full;
    logic [3:0] e_trob;
  } vec_t;

  typedef struct {
    logic [2:0] rw;
    logic [3:0] tp;
    logic [3:0] to;
  } sb_t;

  sb_t sb [$];
  int  cnt;
  int  checks;
  int  errors;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit d, logic [2:0] rw, logic [3:0] tp,
                              logic [3:0] to, bit av, logic [3:0] at,
                              bit mv, logic [3:0] mt, bit stp);
    vec_t v;
    v = '{default: 0};
    v.disp = d; v.rw = rw; v.tp = tp; v.to = to;
    v.av = av; v.at = at; v.mv = mv; v.mt = mt; v.stp = stp;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    valid_issue_reg = 1'b0;
    valid_Result_add = 1'b0;
    valid_Result_mul = 1'b0;
    stop = 1'b0;
    #2 rst = 1'b0;
    sb.delete();
    cnt = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive one cycle's inputs at negedge and run the scoreboard.
  task automatic begin_cycle(input vec_t v);
    bit acc;
    sb_t e;
    @(negedge clk);
    acc = v.disp && !v.stp && (cnt < 16);
    valid_issue_reg  = v.disp;
    Rw_reg           = v.rw;
    tag_PRF          = v.tp;
    tag_Rw_old       = v.to;
    valid_Result_add = v.av;
    tag_ROB_add      = v.at;
    valid_Result_mul = v.mv;
    tag_ROB_mul      = v.mt;
    stop             = v.stp;
    if (commit_valid) begin
      chk("free_valid", 32'(free_valid), 32'd1);
      if (sb.size() == 0) begin
        chk("sb_unexpected_commit", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_commit_Rw", 32'(commit_Rw), 32'(e.rw));
        chk("sb_commit_tag_PRF", 32'(commit_tag_PRF), 32'(e.tp));
        chk("sb_free_tag", 32'(free_tag), 32'(e.to));
      end
      cnt--;
    end else begin
      chk("free_valid_idle", 32'(free_valid), 32'd0);
    end
    if (acc) begin
      sb.push_back('{rw: v.rw, tp: v.tp, to: v.to});
      cnt++;
    end
  endtask

  task automatic idle_cycle();
    begin_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
  endtask

  vec_t tbl [$];
  vec_t v;
  int   n;

  initial begin
    checks = 0;
    errors = 0;
    cnt = 0;

    // Single instruction: Rw=3 tagP=9 old=3
    v = mk(1, 3, 9, 3, 0, 0, 0, 0, 0);
    v.rst_before = 1; v.e_empty = 1; v.e_trob = 0; tbl.push_back(v);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.e_trob = 1; tbl.push_back(v);
    v = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    v.e_trob = 1; tbl.push_back(v);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.e_cv = 1; v.e_free = 3; v.e_trob = 1; tbl.push_back(v);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.e_empty = 1; v.e_trob = 1; tbl.push_back(v);
    // Out-of-order completion of tags 0,1,2
    v = mk(1, 1, 10, 1, 0, 0, 0, 0, 0);
    v.rst_before = 1; v.e_empty = 1; v.e_trob = 0; tbl.push_back(v);
    v = mk(1, 2, 11, 2, 0, 0, 0, 0, 0);
    v.e_trob = 1; tbl.push_back(v);
    v = mk(1, 4, 12, 4, 0, 0, 0, 0, 0);
    v.e_trob = 2; tbl.push_back(v);
    v = mk(0, 0, 0, 0, 1, 2, 0, 0, 0);
    v.e_trob = 3; tbl.push_back(v);
    v = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
    v.e_trob = 3; tbl.push_back(v);
    v = mk(0, 0, 0, 0, 1, 0, 0, 0, 0);
    v.e_trob = 3; tbl.push_back(v);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.e_cv = 1; v.e_free = 1; v.e_trob = 3; tbl.push_back(v);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.e_cv = 1; v.e_free = 2; v.e_trob = 3; tbl.push_back(v);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.e_cv = 1; v.e_free = 4; v.e_trob = 3; tbl.push_back(v);
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.e_empty = 1; v.e_trob = 3; tbl.push_back(v);

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_empty", 32'(empty_ROB), 32'd1);
    chk("rst_full", 32'(full_ROB), 32'd0);
    chk("rst_tag_ROB", 32'(tag_ROB), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_commit_Rw", 32'(commit_Rw), 32'd0);
    chk("rst_commit_tag_PRF", 32'(commit_tag_PRF), 32'd0);
    chk("rst_free_tag", 32'(free_tag), 32'd0);
    for (int i = 0; i < 8; i++) chk("rst_arf", 32'(arf[i]), 32'(i));

    // Table-driven sequences
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_reset();
      begin_cycle(tbl[i]);
      chk("tbl_commit_valid", 32'(commit_valid), 32'(tbl[i].e_cv));
      if (tbl[i].e_cv)
        chk("tbl_free_tag", 32'(free_tag), 32'(tbl[i].e_free));
      chk("tbl_empty", 32'(empty_ROB), 32'(tbl[i].e_empty));
      chk("tbl_full", 32'(full_ROB), 32'(tbl[i].e_full));
      chk("tbl_tag_ROB", 32'(tag_ROB), 32'(tbl[i].e_trob));
      @(posedge clk);
    end
    @(negedge clk);
    chk("ooo_arf1", 32'(arf[1]), 32'd10);
    chk("ooo_arf2", 32'(arf[2]), 32'd11);
    chk("ooo_arf4", 32'(arf[4]), 32'd12);

    // Single instruction ARF update (fresh run)
    do_reset();
    begin_cycle(mk(1, 3, 9, 3, 0, 0, 0, 0, 0)); @(posedge clk);
    idle_cycle();
    begin_cycle(mk(0, 0, 0, 0, 1, 0, 0, 0, 0)); @(posedge clk);
    idle_cycle();
    @(negedge clk);
    chk("single_arf3", 32'(arf[3]), 32'd9);
    chk("single_empty", 32'(empty_ROB), 32'd1);

    // Full and wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      begin_cycle(mk(1, 3'(i), 4'(i), 4'(i + 3), 0, 0, 0, 0, 0));
      chk("fill_tag_ROB", 32'(tag_ROB), 32'(i));
      chk("fill_full", 32'(full_ROB), 32'd0);
      @(posedge clk);
    end
    begin_cycle(mk(1, 0, 1, 2, 0, 0, 0, 0, 0));
    chk("full_flag", 32'(full_ROB), 32'd1);
    chk("full_tag_ROB", 32'(tag_ROB), 32'd0);
    @(posedge clk);
    begin_cycle(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    chk("full_17th_ignored", 32'(tag_ROB), 32'd0);
    chk("full_still", 32'(full_ROB), 32'd1);
    @(posedge clk);
    begin_cycle(mk(1, 7, 5, 6, 0, 0, 0, 0, 0));
    chk("wrap_commit", 32'(commit_valid), 32'd1);
    chk("wrap_full_same_cycle", 32'(full_ROB), 32'd1);
    @(posedge clk);
    begin_cycle(mk(1, 7, 5, 6, 0, 0, 0, 0, 0));
    chk("wrap_not_full", 32'(full_ROB), 32'd0);
    chk("wrap_tag0", 32'(tag_ROB), 32'd0);
    @(posedge clk);
    begin_cycle(mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    chk("wrap_tag1", 32'(tag_ROB), 32'd1);
    chk("wrap_full_again", 32'(full_ROB), 32'd1);
    @(posedge clk);
    for (int i = 2; i < 17; i++) begin
      begin_cycle(mk(0, 0, 0, 0, 1, 4'(i), 0, 0, 0));
      @(posedge clk);
    end
    n = 0;
    while (!empty_ROB && n < 40) begin
      idle_cycle();
      n++;
    end
    chk("wrap_drain_timeout", 32'(n < 40), 32'd1);
    @(negedge clk);
    chk("wrap_empty", 32'(empty_ROB), 32'd1);
    chk("wrap_tag_ROB", 32'(tag_ROB), 32'd1);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);
    chk("wrap_arf7", 32'(arf[7]), 32'd5);

    // Simultaneous broadcasts
    do_reset();
    for (int i = 0; i < 6; i++) begin
      begin_cycle(mk(1, 3'(i + 1), 4'(i + 8), 4'(i), 0, 0, 0, 0, 0));
      @(posedge clk);
    end
    begin_cycle(mk(0, 0, 0, 0, 1, 1, 1, 2, 0));
    chk("sim_no_commit", 32'(commit_valid), 32'd0);
    @(posedge clk);
    begin_cycle(mk(0, 0, 0, 0, 1, 3, 1, 0, 0));
    chk("sim_no_commit2", 32'(commit_valid), 32'd0);
    @(posedge clk);
    begin_cycle(mk(0, 0, 0, 0, 1, 4, 1, 5, 0));
    chk("sim_commit0", 32'(commit_valid), 32'd1);
    @(posedge clk);
    for (int i = 1; i < 6; i++) begin
      begin_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("sim_commit_run", 32'(commit_valid), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("sim_empty", 32'(empty_ROB), 32'd1);
    chk("sim_arf6", 32'(arf[6]), 32'd13);

    // stop
    do_reset();
    begin_cycle(mk(1, 2, 14, 2, 0, 0, 0, 0, 0)); @(posedge clk);
    begin_cycle(mk(1, 5, 15, 5, 0, 0, 0, 0, 0)); @(posedge clk);
    begin_cycle(mk(0, 0, 0, 0, 1, 0, 1, 1, 0)); @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      begin_cycle(mk(1, 6, 7, 6, 0, 0, 0, 0, 1));
      chk("stop_tag_frozen", 32'(tag_ROB), 32'd2);
      chk("stop_commit", 32'(commit_valid), 32'(i < 2));
      @(posedge clk);
    end
    begin_cycle(mk(1, 6, 7, 6, 0, 0, 0, 0, 0));
    chk("stop_empty", 32'(empty_ROB), 32'd1);
    chk("stop_tag", 32'(tag_ROB), 32'd2);
    @(posedge clk);
    idle_cycle();
    @(negedge clk);
    chk("stop_resume_tag", 32'(tag_ROB), 32'd3);
    chk("stop_arf5", 32'(arf[5]), 32'd15);

    // Reset mid-run with 5 entries valid
    do_reset();
    begin_cycle(mk(1, 5, 13, 5, 0, 0, 0, 0, 0)); @(posedge clk);
    begin_cycle(mk(0, 0, 0, 0, 1, 0, 0, 0, 0)); @(posedge clk);
    idle_cycle();
    for (int i = 0; i < 5; i++) begin
      begin_cycle(mk(1, 3'(i), 4'(i + 2), 4'(i), 0, 0, 0, 0, 0));
      @(posedge clk);
    end
    begin_cycle(mk(0, 0, 0, 0, 1, 2, 1, 3, 0)); @(posedge clk);
    @(negedge clk);
    chk("mid_arf5_set", 32'(arf[5]), 32'd13);
    chk("mid_not_empty", 32'(empty_ROB), 32'd0);
    do_reset();
    #1;
    chk("mid_empty", 32'(empty_ROB), 32'd1);
    chk("mid_tag_ROB", 32'(tag_ROB), 32'd0);
    chk("mid_arf5", 32'(arf[5]), 32'd5);
    for (int i = 0; i < 8; i++) chk("mid_arf", 32'(arf[i]), 32'(i));
    for (int i = 0; i < 20; i++) begin
      begin_cycle(mk(0, 0, 0, 0, 1, 4'(i), 1, 4'(i + 1), 0));
      chk("mid_no_commit", 32'(commit_valid), 32'd0);
      @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement queue for the back end. Accepts one renamed instruction per cycle from the front end's issue register and allocates a ROB tag for it. Marks entries complete from the add/mul result broadcasts. Retires the oldest completed entry each cycle, updating the committed architectural map `ARF_tag` and returning the superseded physical tag to the PRF free list.

## Interface
- `DEPTH`, 16: ROB entries; power of two; tag width = log2(DEPTH) = 4.
- `NAREG`, 8: architectural registers; `Rw_reg` width 3.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `stop` in 1: program halted; blocks allocation, retirement continues.
- `valid_issue_reg` in 1: dispatch request this cycle.
- `Rw_reg` in 3: destination architectural register of the dispatched instruction.
- `tag_PRF` in 4: newly allocated physical tag for `Rw_reg`.
- `tag_Rw_old` in 4: previous speculative mapping of `Rw_reg`.
- `tag_ROB` out 4: tag the next dispatch receives (tail pointer).
- `full_ROB` out 1: no free entry.
- `empty_ROB` out 1: no valid entry.
- `valid_Result_add` in 1: add unit result broadcast valid.
- `tag_ROB_add` in 4: ROB tag of the add result.
- `valid_Result_mul` in 1: mul unit result broadcast valid.
- `tag_ROB_mul` in 4: ROB tag of the mul result.
- `commit_valid` out 1: head retires at this edge.
- `commit_Rw` out 3: architectural register being retired.
- `commit_tag_PRF` out 4: physical tag becoming committed.
- `free_valid` out 1: equals `commit_valid`.
- `free_tag` out 4: `tag_Rw_old` of the retiring entry, returned to the free list.
- `ARF_tag[0:7]` out 4 each: committed architectural→physical map.

## Operation
- **Storage:** per entry `valid`, `done`, `Rw` (3b), `tagP` (4b), `tagOld` (4b). Pointers `head` and `tail` are 4b each and wrap 15→0. `count` is 5b, range 0..16.
- **Flags:** `full_ROB = (count == 16)`, `empty_ROB = (count == 0)`. Both come from registered state only; a same-cycle retirement does not make room for a same-cycle dispatch.
- **Allocate:** allocation occurs when `valid_issue_reg && !full_ROB && !stop`. It writes the entry at `tail` with `valid=1`, `done=0` and the input fields, then increments `tail`. When the condition is false, the request is ignored and no state changes. The front end must hold the request.
- **Complete:** on `valid_Result_add`, set `done[tag_ROB_add]`; likewise for mul, independently. Both may target the same or different entries in one cycle. A broadcast to an entry with `valid=0` is ignored. A broadcast to an already-done entry has no effect.
- **Retire (combinational decision):** `commit_valid = valid[head] && done[head]`. `commit_Rw`, `commit_tag_PRF` and `free_tag` are driven from the head entry.
  - Outputs are 0 when `commit_valid=0`.
  - At the edge, retirement clears `valid[head]`, increments `head` and writes `ARF_tag[Rw] <= tagP`.
- **Count update:** `count` changes by +alloc −commit; simultaneous alloc and commit leave it unchanged.
- **Throughput:** at most one retirement per cycle. Retirement stays strictly in order: a done younger entry waits behind a not-done head.
- **Reset (rst=0, async):**
  - All `valid` and `done` cleared; `head = tail = count = 0`.
  - `ARF_tag[i] = i` for i=0..7.
  - Outputs: `tag_ROB=0`, `full_ROB=0`, `empty_ROB=1`, `commit_valid=free_valid=0`, `commit_Rw=0`, `commit_tag_PRF=0`, `free_tag=0`.
  - A reset mid-operation discards all in-flight entries; none retire.

## Timing
- Dispatch sampled at edge N. The entry is visible from N+1, and `tag_ROB` advances at N+1.
- A completion sampled at edge M≥N+1 sets `done` at M. If the entry is at head, `commit_valid` is high during cycle M→M+1 and retirement happens at edge M+1. Minimum complete→retire latency is 1 cycle.
- A completion in the same cycle as that entry's dispatch cannot occur and is ignored, because the entry is not yet valid.
- `ARF_tag` updates at the retirement edge and is visible the following cycle.
- `full_ROB` and `empty_ROB` are registered-state decodes with no combinational path from the inputs.
- Retirement outputs depend combinationally only on head state.

## Test plan
- **Reset:** assert rst low mid-run with 5 entries valid -> `empty_ROB=1`, `tag_ROB=0`, `ARF_tag[i]=i`, no `commit_valid` afterwards.
- **Single instruction:** dispatch Rw=3, tagP=9, old=3; add-complete tag 0 two cycles later -> next cycle `commit_valid=1`, `free_tag=3`; then `ARF_tag[3]=9` and `empty_ROB=1`.
- **Out-of-order completion:** dispatch tags 0,1,2; complete 2, then 1, then 0 -> retirements in order 0,1,2 on three consecutive cycles starting the cycle after tag 0 completes.
- **Full/wrap:**
  - 16 dispatches -> `full_ROB=1`, and a 17th dispatch is ignored.
  - Complete the head, then dispatch again the same cycle as the retirement -> that dispatch is rejected and accepted next cycle at tag 0. `head`/`tail` wrap correctly.
- **Simultaneous broadcasts:** add and mul complete tags 4 and 5 in the same cycle (with 0–3 already done) -> both marked done; 6 retirements on consecutive cycles.
- **stop:** with `stop=1`, dispatch is ignored while pending completions still retire; `tag_ROB` stays frozen.
